fc_layer: RTL and testbench
===========================

// Module: fc_layer
//
// PURPOSE
// - Fully-connected neural-network layer: OUT_N neurons share one IN_N-element
//   signed input vector.
// - Each neuron computes a dot product with its own weight row, adds its bias,
//   applies ReLU and saturates the result to DATA_WIDTH.
// - Two-stage pipeline, one new vector accepted per clock.
// - Sits between successive layers of the NPU datapath.
//
// PARAMETERS
// - IN_N        4   number of inputs (weight-row length)
// - OUT_N       4   number of neurons/outputs
// - DATA_WIDTH  8   signed two's-complement width of x, w, b, y
// - ACC_WIDTH   32  signed accumulator width
//   - Must be >= 2*DATA_WIDTH + $clog2(IN_N+1).
//
// PORTS
// - clk      in   1                      single clock, rising edge
// - rst      in   1                      asynchronous, active-high reset
// - in_vec   in   IN_N*DATA_WIDTH        x[j] = in_vec[j*DW +: DW]
// - weights  in   OUT_N*IN_N*DATA_WIDTH  w[i][j] = weights[(i*IN_N+j)*DW +: DW]
//                                        (neuron i, input j)
// - biases   in   OUT_N*DATA_WIDTH       b[i] = biases[i*DW +: DW]
// - out_vec  out  OUT_N*DATA_WIDTH       y[i] = out_vec[i*DW +: DW]
//
// BEHAVIOUR
// - Pure integer arithmetic; all values signed; no fractional scaling.
// - Stage 1 (edge N):
//   - acc_r[i] <= b[i] + sum_j(x[j]*w[i][j]), evaluated in ACC_WIDTH.
//   - Products and bias are sign-extended before summing.
// - Stage 2 (edge N+1):
//   - Activation: if acc_r[i] < 0, y[i] <= 0.
//   - Else if acc_r[i] > 2^(DW-1)-1, y[i] <= 2^(DW-1)-1.
//   - Else y[i] <= acc_r[i][DW-1:0].
// - Latency: inputs stable before edge N give the matching out_vec after
//   edge N+1 (2 edges).
// - out_vec is driven only from stage-2 registers; it does not change
//   between edges.
// - Throughput: one vector per cycle. No handshake and no valid/ready;
//   inputs are sampled every edge.
// - Reset: while rst = 1, all acc_r and y registers clear to 0 immediately,
//   without waiting for a clock edge. Therefore out_vec = 0 during reset.
// - Reset deasserted: the first meaningful output appears 2 edges after the
//   first sampled vector.
//   - The output after the first edge following release is ReLU(0) = 0
//     (cleared stage-1 register).
// - Reset mid-stream: vectors in flight are discarded, with no partial
//   output.
// - Boundaries:
//   - Accumulator sum exactly 0 gives y = 0.
//   - Exactly 2^(DW-1)-1 passes through unchanged.
//   - Most-negative operands (-2^(DW-1)) are handled with no overflow, given
//     the ACC_WIDTH rule.
// - X/Z on inputs propagates; no masking.
// - Neurons are independent; out_vec slice i depends only on x, w[i][*]
//   and b[i].
//
// TESTING (DW=8, IN_N=2, OUT_N=2)
// - Reset: rst=1 with random inputs -> out_vec=0 immediately and for every
//   edge while rst is held.
// - Dot product: x={1,2}, w0={3,4}, b0=5; w1={-1,-1}, b1=0
//   -> 2 edges later y0=16, y1=0 (ReLU of -3).
// - Saturation: x={100,100}, w0={100,100}, b0=0; w1={-128,-128}, b1=0
//   -> y0=127, y1=0.
// - Bias only / extremes: x={0,0}, b={-128,127} -> y={0,127};
//   x={-128,-128}, w0={-128,-128}, b0=-128 -> y0=127.
// - Pipelining: apply a new vector every cycle (cases above back-to-back)
//   -> results emerge in order, each exactly 2 edges after its input, with
//   no bubbles.
// - Mid-stream reset: pulse rst for under 1 cycle between edges
//   -> out_vec=0 at once; the next valid result comes 2 edges after the next
//   sampled vector.

Source files
------------

// File: rtl/fc_layer.sv
// ---------------------------------------------------------------------------
// fc_layer
//
// Fully-connected neural-network layer. OUT_N neurons share one IN_N-element
// signed input vector. Each neuron forms the dot product of the vector with
// its own weight row, adds its bias, applies ReLU and saturates the result
// to DATA_WIDTH. The layer is a two-stage pipeline that accepts a new vector
// on every clock. There is no handshake.
//
// Ports
//   clk      in   1                      rising-edge clock
//   rst      in   1                      asynchronous, active-high reset
//   in_vec   in   IN_N*DATA_WIDTH        x[j]    = in_vec[j*DW +: DW]
//   weights  in   OUT_N*IN_N*DATA_WIDTH  w[i][j] = weights[(i*IN_N+j)*DW +: DW]
//   biases   in   OUT_N*DATA_WIDTH       b[i]    = biases[i*DW +: DW]
//   out_vec  out  OUT_N*DATA_WIDTH       y[i]    = out_vec[i*DW +: DW]
//
// ACC_WIDTH must be at least 2*DATA_WIDTH + $clog2(IN_N+1). With that width
// even all-most-negative operands cannot overflow the accumulator.
// ---------------------------------------------------------------------------
module fc_layer #(
    parameter int IN_N       = 4,
    parameter int OUT_N      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_N*DATA_WIDTH-1:0]       in_vec,
    input  logic [OUT_N*IN_N*DATA_WIDTH-1:0] weights,
    input  logic [OUT_N*DATA_WIDTH-1:0]      biases,
    output logic [OUT_N*DATA_WIDTH-1:0]      out_vec
);

    localparam int DW = DATA_WIDTH;

    // Largest positive DW-bit value, held at accumulator width so that the
    // clamp comparison is a signed ACC_WIDTH compare.
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
        {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};

    // The input vector is shared by every neuron.
    logic signed [DW-1:0] x_arr [IN_N];

    genvar gi;
    genvar gj;

    generate
        for (gi = 0; gi < IN_N; gi++) begin : g_x
            assign x_arr[gi] = in_vec[gi*DW +: DW];
        end

        for (gi = 0; gi < OUT_N; gi++) begin : g_neuron
            logic signed [DW-1:0]        w_row [IN_N];
            logic signed [DW-1:0]        bias;
            logic signed [2*DW-1:0]      prod;
            logic signed [ACC_WIDTH-1:0] acc_next;
            logic signed [ACC_WIDTH-1:0] acc_reg;
            logic        [DW-1:0]        y_next;
            logic        [DW-1:0]        y_reg;

            for (gj = 0; gj < IN_N; gj++) begin : g_w
                assign w_row[gj] = weights[(gi*IN_N+gj)*DW +: DW];
            end

            assign bias = biases[gi*DW +: DW];

            // Stage 1: bias plus sum of products. Each product is a full
            // 2*DW-bit signed result, sign-extended before it is added.
            always_comb begin
                prod     = '0;
                acc_next = {{(ACC_WIDTH-DW){bias[DW-1]}}, bias};
                for (int j = 0; j < IN_N; j++) begin
                    prod     = x_arr[j] * w_row[j];
                    acc_next = acc_next + {{(ACC_WIDTH-2*DW){prod[2*DW-1]}}, prod};
                end
            end

            // Stage 2: ReLU followed by saturation to the largest positive
            // DW-bit value. In-range values keep their low DW bits.
            always_comb begin
                y_next = '0;
                if (acc_reg < 0) begin
                    y_next = '0;
                end else if (acc_reg > Y_MAX) begin
                    y_next = {1'b0, {(DW-1){1'b1}}};
                end else begin
                    y_next = acc_reg[DW-1:0];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                    y_reg   <= '0;
                end else begin
                    acc_reg <= acc_next;
                    y_reg   <= y_next;
                end
            end

            assign out_vec[gi*DW +: DW] = y_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fc_layer.sv
// ---------------------------------------------------------------------------
// tb_fc_layer
//
// Testbench for fc_layer with IN_N=2, OUT_N=2 and DATA_WIDTH=8. A plain
// integer reference model computes each neuron's output, and a two-deep
// delay line of expected vectors models the pipeline latency. Directed
// vectors also carry hand-computed literal results. Those literals are
// compared against the DUT when the matching result emerges.
// ---------------------------------------------------------------------------
module tb_fc_layer;

    localparam int IN_N  = 2;
    localparam int OUT_N = 2;
    localparam int DW    = 8;
    localparam int ACCW  = 32;

    logic                     clk;
    logic                     rst;
    logic [IN_N*DW-1:0]       in_vec;
    logic [OUT_N*IN_N*DW-1:0] weights;
    logic [OUT_N*DW-1:0]      biases;
    logic [OUT_N*DW-1:0]      out_vec;

    fc_layer #(
        .IN_N      (IN_N),
        .OUT_N     (OUT_N),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (ACCW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_vec (in_vec),
        .weights(weights),
        .biases (biases),
        .out_vec(out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Current stimulus, held as plain integers.
    int xv [IN_N];
    int wv [OUT_N][IN_N];
    int bv [OUT_N];

    // Expected pipeline contents.
    logic [OUT_N*DW-1:0] s1_exp;
    logic [OUT_N*DW-1:0] out_exp;

    // Literal expectations for directed vectors, delayed in the same way.
    logic                pend_v, lit_s1_v, lit_out_v;
    logic [OUT_N*DW-1:0] pend, lit_s1, lit_out;

    function automatic logic [OUT_N*DW-1:0] model_out();
        logic [OUT_N*DW-1:0] res;
        int acc;
        int y;
        logic [31:0] yb;
        res = '0;
        for (int i = 0; i < OUT_N; i++) begin
            acc = bv[i];
            for (int j = 0; j < IN_N; j++) acc += xv[j] * wv[i][j];
            if (acc < 0)        y = 0;
            else if (acc > 127) y = 127;
            else                y = acc;
            yb = y;
            res[i*DW +: DW] = yb[DW-1:0];
        end
        return res;
    endfunction

    task automatic drive();
        logic [31:0] t;
        for (int j = 0; j < IN_N; j++) begin
            t = xv[j];
            in_vec[j*DW +: DW] = t[DW-1:0];
        end
        for (int i = 0; i < OUT_N; i++) begin
            t = bv[i];
            biases[i*DW +: DW] = t[DW-1:0];
            for (int j = 0; j < IN_N; j++) begin
                t = wv[i][j];
                weights[(i*IN_N+j)*DW +: DW] = t[DW-1:0];
            end
        end
    endtask

    task automatic randomize_inputs();
        for (int j = 0; j < IN_N; j++) xv[j] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < OUT_N; i++) begin
            bv[i] = int'($urandom_range(255, 0)) - 128;
            for (int j = 0; j < IN_N; j++) wv[i][j] = int'($urandom_range(255, 0)) - 128;
        end
        drive();
    endtask

    task automatic set_vec(input int x0, input int x1,
                           input int w00, input int w01, input int b0,
                           input int w10, input int w11, input int b1,
                           input logic [OUT_N*DW-1:0] lit);
        xv[0] = x0; xv[1] = x1;
        wv[0][0] = w00; wv[0][1] = w01; bv[0] = b0;
        wv[1][0] = w10; wv[1][1] = w11; bv[1] = b1;
        drive();
        pend_v = 1'b1;
        pend   = lit;
    endtask

    task automatic check(input string tag, input logic [OUT_N*DW-1:0] obs,
                         input logic [OUT_N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: out_vec=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the expected pipeline, then sample the DUT
    // 1 ns after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) begin
            out_exp   = '0;
            s1_exp    = '0;
            lit_out_v = 1'b0;
            lit_s1_v  = 1'b0;
        end else begin
            out_exp   = s1_exp;
            s1_exp    = model_out();
            lit_out_v = lit_s1_v;
            lit_out   = lit_s1;
            lit_s1_v  = pend_v;
            lit_s1    = pend;
        end
        pend_v = 1'b0;
        #1;
        check(tag, out_vec, out_exp);
        if (lit_out_v) check({tag, "_literal"}, out_vec, lit_out);
        $display("t=%0t %s x=%h w=%h b=%h out=%h exp=%h",
                 $time, tag, in_vec, weights, biases, out_vec, out_exp);
    endtask

    initial begin
        pend_v = 1'b0; lit_s1_v = 1'b0; lit_out_v = 1'b0;
        pend = '0; lit_s1 = '0; lit_out = '0;
        s1_exp = '0; out_exp = '0;

        // The reset clears the registers immediately. Random inputs are applied, and out_vec must be 0 before any edge.
        rst = 1'b1;
        randomize_inputs();
        #1;
        check("reset_async", out_vec, '0);
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            cycle("reset_held");
        end

        // Release reset between edges. The first edge after release shows
        // the cleared stage-1 register (0).
        rst = 1'b0;

        // Directed cases back-to-back, one per cycle.
        set_vec(1, 2,       3, 4, 5,          -1, -1, 0,      {8'd0,   8'd16});
        cycle("dot_product");
        set_vec(100, 100,   100, 100, 0,      -128, -128, 0,  {8'd0,   8'd127});
        cycle("saturation");
        set_vec(0, 0,       37, -90, -128,    -5, 77, 127,    {8'd127, 8'd0});
        cycle("bias_only");
        set_vec(-128, -128, -128, -128, -128, 1, 1, 0,        {8'd0,   8'd127});
        cycle("extremes");
        set_vec(1, 2,       127, 0, 0,        2, -1, 0,       {8'd0,   8'd127});
        cycle("exact_max_zero");
        set_vec(10, -3,     5, 2, -1,         -4, -4, 100,    {8'd72,  8'd43});
        cycle("passthrough");

        // Random vectors streamed every cycle.
        for (int k = 0; k < 20; k++) begin
            randomize_inputs();
            cycle("random");
        end

        // Mid-stream reset pulse shorter than one cycle, between edges.
        rst = 1'b1;
        #1;
        out_exp = '0; s1_exp = '0;
        lit_out_v = 1'b0; lit_s1_v = 1'b0; pend_v = 1'b0;
        check("midreset_async", out_vec, '0);
        #2;
        rst = 1'b0;
        cycle("after_midreset");
        set_vec(1, 2,       3, 4, 5,          -1, -1, 0,      {8'd0,   8'd16});
        cycle("post_reset_dot");
        for (int k = 0; k < 10; k++) begin
            randomize_inputs();
            cycle("random_post");
        end
        cycle("drain1");
        cycle("drain2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
